// File: rtl/shift_register_sequencer.sv
// Parallel-load serial shift sequencer: loads a word, shifts it out on SO while sampling SI,
// then presents the received word for one cycle. Define SHIFT_REGISTER_SEQUENCER_LSB_FIRST_EN
// for LSB-first shifting; the default build is MSB-first.
module shift_register_sequencer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             C,
    input  logic             CLRN,
    input  logic             LD_VALID,
    input  logic [WIDTH-1:0] LD_DATA,
    output logic             LD_READY,
    input  logic             HOLD,
    input  logic             SI,
    output logic             SO,
    output logic             FRAME,
    output logic             RX_VALID,
    output logic [WIDTH-1:0] RX_DATA
);

    localparam int unsigned     CntW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StDone  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  shreg_q, shreg_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]  shifted;
    logic              out_bit;

`ifdef SHIFT_REGISTER_SEQUENCER_LSB_FIRST_EN
    assign shifted = {SI, shreg_q[WIDTH-1:1]};
    assign out_bit = shreg_q[0];
`else
    assign shifted = {shreg_q[WIDTH-2:0], SI};
    assign out_bit = shreg_q[WIDTH-1];
`endif

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (LD_VALID) begin
                    shreg_d = LD_DATA;
                    cnt_d   = '0;
                    state_d = StShift;
                end
            end
            StShift: begin
                if (!HOLD) begin
                    shreg_d = shifted;
                    // Final shift leaves the counter at its last value so it never wraps.
                    if (cnt_q == CntLast) begin
                        state_d = StDone;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge C) begin
        if (!CLRN) begin
            state_q <= StIdle;
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs are masked while CLRN is low so an aborted word disappears immediately.
    always_comb begin
        LD_READY = CLRN && (state_q == StIdle);
        FRAME    = CLRN && (state_q == StShift);
        RX_VALID = CLRN && (state_q == StDone);
        SO       = FRAME && out_bit;
        RX_DATA  = RX_VALID ? shreg_q : '0;
    end

endmodule

// File: doc/shift_register_sequencer.md
SHIFT_REGISTER_SEQUENCER -- requirements
Module: shift_register_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning shift word length in bits (legal range 2..32).
REQ-002 SHALL have port C  input  1  clock; all state changes on its rising edge.
REQ-003 SHALL have port CLRN  input  1  reset; synchronous, active-low.
REQ-004 SHALL have port LD_VALID  input  1  requester offers a parallel word.
REQ-005 SHALL have port LD_DATA  input  WIDTH  parallel word to transmit.
REQ-006 SHALL have port LD_READY  output  1  sequencer accepts a word this cycle.
REQ-007 SHALL have port HOLD  input  1  pause shifting while high.
REQ-008 SHALL have port SI  input  1  serial data in.
REQ-009 SHALL have port SO  output  1  serial data out.
REQ-010 SHALL have port FRAME  output  1  high while a word is being shifted.
REQ-011 SHALL have port RX_VALID  output  1  one-cycle pulse when a received word is complete.
REQ-012 SHALL have port RX_DATA  output  WIDTH  word assembled from SI; valid while RX_VALID is high.

Function
REQ-013 SHALL implement three states: IDLE, SHIFT and DONE.
REQ-014 SHALL drive LD_READY=1 only in IDLE.
REQ-015 Transfer condition:
- In IDLE with LD_VALID=1 at an edge: SHALL load LD_DATA into the WIDTH-bit shift register, clear the bit counter and enter SHIFT.
- In IDLE with LD_VALID=0: SHALL stay in IDLE and leave the register unchanged.
REQ-016 In SHIFT with HOLD=0, each edge SHALL:
- shift the register left: {reg[WIDTH-2:0], SI};
- increment the counter.
REQ-017 In SHIFT with HOLD=1, SHALL freeze the register, the counter and the state; FRAME stays 1.
REQ-018 SHALL drive SO = reg[WIDTH-1] when FRAME=1, and SO = 0 otherwise.
REQ-019 SHALL drive FRAME=1 exactly in SHIFT.
REQ-020 End of word: on the non-held edge where counter = WIDTH-1, SHALL enter DONE; exactly WIDTH non-held SHIFT cycles per word.
REQ-021 In DONE, SHALL:
- drive RX_VALID=1 for one cycle;
- drive RX_DATA = register contents, with the first-sampled SI bit at the MSB;
- then enter IDLE unconditionally.
REQ-022 SHALL drive RX_DATA = 0 when RX_VALID=0.
REQ-023 SHALL ignore LD_VALID and LD_DATA outside IDLE; no queuing, and the requester holds its request.
REQ-024 SHALL ignore HOLD outside SHIFT.
REQ-025 SHALL make the minimum back-to-back word period WIDTH+2 cycles: accept, WIDTH shifts, DONE.
REQ-026 SHALL size the counter at clog2(WIDTH) bits and never let it wrap within a word.

Reset
REQ-027 CLRN=0 at an edge SHALL force IDLE, register=0 and counter=0.
REQ-028 During reset, outputs SHALL be: LD_READY=0, SO=0, FRAME=0, RX_VALID=0, RX_DATA=0.
REQ-029 The cycle after CLRN returns high, outputs SHALL be: LD_READY=1, SO=0, FRAME=0, RX_VALID=0, RX_DATA=0.
REQ-030 Reset during SHIFT or DONE SHALL abort the word with no RX_VALID pulse; reset SHALL take priority over all inputs.

Configuration
REQ-031 SHALL provide macro SHIFT_REGISTER_SEQUENCER_LSB_FIRST_EN.
REQ-032 With the macro defined, SHALL:
- shift right: {SI, reg[WIDTH-1:1]};
- drive SO = reg[0];
- place the first-sampled SI bit at the LSB of RX_DATA.
REQ-033 With the macro undefined, SHALL use the MSB-first behaviour of REQ-016, REQ-018 and REQ-021.
REQ-034 The macro SHALL not change state timing, handshake or the reset behaviour.

Verification (WIDTH=8)
REQ-035 SHALL cover this scenario: load 0xA5 with SI=0 and HOLD=0 -> SO=1,0,1,0,0,1,0,1 on the 8 FRAME cycles; then RX_VALID for one cycle with RX_DATA=0x00; then LD_READY=1.
REQ-036 SHALL cover this scenario: load 0x00 with SI driven 1,1,0,0,1,1,0,0 on the FRAME cycles -> RX_DATA=0xCC with RX_VALID.
REQ-037 SHALL cover this scenario: load 0xFF with HOLD=1 for 3 cycles after the 4th shift -> FRAME stays high for 11 cycles, SO=1 throughout, RX_VALID at cycle 12 after accept.
REQ-038 SHALL cover this scenario: LD_VALID held high continuously with 0x81 -> accepts every 10 cycles, LD_READY low between accepts.
REQ-039 SHALL cover this scenario: CLRN=0 on the 5th SHIFT cycle -> next cycle FRAME=0, SO=0, no RX_VALID; LD_READY=1 one cycle after CLRN=1.
REQ-040 SHALL cover this scenario: with the macro defined, load 0xA5 with SI=0 -> SO=1,0,1,0,0,1,0,1 (LSB first); SI pattern 1,0,0,0,0,0,0,0 -> RX_DATA=0x01.
